// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, sequencer state encoding and op codes.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell, the only arithmetic element of the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : full_adder

// File: rtl/serial_subtractor.sv
// Bit-serial add/subtract unit: one bit per clock through one full_adder, LSB first,
// with a start/busy/done handshake towards the ALU sequencer.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sum_c;
    logic             cout_c;

    full_adder u_full_adder (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (cy_q),
        .Y    (sum_c),
        .Cout (cout_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operands shift right alongside Y, so bit 0 always holds the current bit and,
    // on the last bit, the original MSBs needed for the overflow test.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = (op == OP_SUB) ? ~B : B;
                    cy_d    = op;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                y_d    = {sum_c, y_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                cy_d   = cout_c;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    carry_d = cout_c;
                    ovf_d   = (a_q[0] == b_q[0]) && (sum_c != a_q[0]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Y        = y_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: expected results queued at issue, checked at done.
module tb_serial_subtractor;

    localparam int unsigned W   = 8;
    localparam int          LAT = W + 1;
    localparam int          PER = W + 2;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         carry;
    logic         overflow;

    exp_t sb[$];
    int   checks;
    int   errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .A        (a),
        .B        (b),
        .Y        (y),
        .busy     (busy),
        .done     (done),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic done at WIDTH+1 bits.
    function automatic exp_t calc(input logic o, input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W:0]   full;
        logic [W-1:0] zz;
        exp_t         e;
        zz   = o ? ~z : z;
        full = {1'b0, x} + {1'b0, zz} + {{W{1'b0}}, o};
        e.y  = full[W-1:0];
        e.c  = full[W];
        e.v  = (x[W-1] == zz[W-1]) && (e.y[W-1] != x[W-1]);
        return e;
    endfunction

    // Issue one op from IDLE (called just after a rising edge), then check latency and result.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] z,
                          input exp_t e, input string name);
        exp_t got;
        bit   seen;
        seen  = 1'b0;
        op    = o;
        a     = x;
        b     = z;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 1'($urandom);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                got  = sb.pop_front();
                checks++;
                if (n !== LAT) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
                end
                checks++;
                if (y !== got.y) begin
                    errors++;
                    $display("FAIL %s Y: got %h want %h", name, y, got.y);
                end
                checks++;
                if (carry !== got.c) begin
                    errors++;
                    $display("FAIL %s carry: got %b want %b", name, carry, got.c);
                end
                checks++;
                if (overflow !== got.v) begin
                    errors++;
                    $display("FAIL %s overflow: got %b want %b", name, overflow, got.v);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %b want 0", name, busy);
                end
            end else if (n < LAT) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_run cycle %0d: got %b want 1", name, n, busy);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout: got no done want done within 20 cycles", name);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({y, busy, done, carry, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got Y=%h b=%b d=%b c=%b v=%b want all 0",
                     y, busy, done, carry, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_arith();
        run_op(1'b1, 8'h05, 8'h03, '{y: 8'h02, c: 1'b1, v: 1'b0}, "sub_05_03");
        run_op(1'b1, 8'h03, 8'h05, '{y: 8'hFE, c: 1'b0, v: 1'b0}, "sub_03_05");
        run_op(1'b1, 8'h80, 8'h01, '{y: 8'h7F, c: 1'b1, v: 1'b1}, "sub_80_01");
        run_op(1'b0, 8'h7F, 8'h01, '{y: 8'h80, c: 1'b0, v: 1'b1}, "add_7F_01");
        run_op(1'b0, 8'hFF, 8'h01, '{y: 8'h00, c: 1'b1, v: 1'b0}, "add_FF_01");
        run_op(1'b1, 8'h00, 8'h00, '{y: 8'h00, c: 1'b1, v: 1'b0}, "sub_00_00");
        for (int k = 0; k < 4; k++) begin
            logic         ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ro, ra, rb, calc(ro, ra, rb), "random_op");
        end
    endtask

    task automatic test_ignore_start();
        int   dones;
        exp_t got;
        dones = 0;
        op    = 1'b1;
        a     = 8'h10;
        b     = 8'h04;
        start = 1'b1;
        sb.push_back('{y: 8'h0C, c: 1'b1, v: 1'b0});
        @(posedge clk); #1;
        for (int n = 1; n <= 14; n++) begin
            start = (n == 3 || n == 9);
            op    = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            @(negedge clk);
            if (done) begin
                dones++;
                checks++;
                if (n !== LAT || sb.size() == 0) begin
                    errors++;
                    $display("FAIL ignore_done_cycle: got cycle %0d want %0d", n, LAT);
                end
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    checks++;
                    if ({y, carry, overflow} !== {got.y, got.c, got.v}) begin
                        errors++;
                        $display("FAIL ignore_result: got Y=%h c=%b v=%b want Y=%h c=%b v=%b",
                                 y, carry, overflow, got.y, got.c, got.v);
                    end
                end
            end
            if (n == 11) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_done_start: got busy=%b want 0", busy);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        op    = 1'b1;
        a     = 8'h55;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y, busy, done, carry, overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got Y=%h b=%b d=%b c=%b v=%b want all 0",
                     y, busy, done, carry, overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard: got done=%b want 0", done);
            end
        end
        @(posedge clk); #1;
        run_op(1'b1, 8'h00, 8'h01, '{y: 8'hFF, c: 1'b0, v: 1'b0}, "post_reset_00_01");
    endtask

    task automatic test_back_to_back();
        exp_t got;
        for (int c = 0; c < 5 * PER; c++) begin
            start = 1'b1;
            op    = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            if (c % PER == 0) sb.push_back(calc(op, a, b));
            @(negedge clk);
            checks++;
            if (done !== (c % PER == LAT)) begin
                errors++;
                $display("FAIL b2b_done_cycle %0d: got %b want %b", c, done, (c % PER == LAT));
            end
            checks++;
            if (done && busy) begin
                errors++;
                $display("FAIL b2b_done_busy %0d: got both high want exclusive", c);
            end
            if (done && sb.size() != 0) begin
                got = sb.pop_front();
                checks++;
                if ({y, carry, overflow} !== {got.y, got.c, got.v}) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got Y=%h c=%b v=%b want Y=%h c=%b v=%b",
                             c, y, carry, overflow, got.y, got.c, got.v);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        @(posedge clk); #1;
        test_arith();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish by 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtract/add unit for the ALU datapath. It computes Y = A − B as A + ~B + 1, or Y = A + B, one bit per clock, LSB first, through a single full_adder cell. This pairs with the parallel combinational adder: the same arithmetic at a fraction of the area, with a start/done handshake so the ALU sequencer can issue an operation and wait for its result.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add (A + B), 1 = subtract (A − B); latched with start.
- A  input  WIDTH  minuend / first addend; latched with start.
- B  input  WIDTH  subtrahend / second addend; latched with start.
- Y  output  WIDTH  result; valid from the done cycle until the next accepted start.
- busy  output  1  high from the cycle after start is accepted through the last bit cycle.
- done  output  1  single-cycle pulse when Y and the flags are valid.
- carry  output  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  signed overflow of the final result.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start = 1. Latch A, op, and B (B inverted when op = 1). Set the carry register to op. Clear the bit counter.
  - RUN: each cycle, feed latched A[i], B'[i] and the carry register into the full_adder. Shift the sum bit into Y at MSB and shift right, so Y is LSB-aligned after WIDTH shifts. Update the carry register and increment the counter.
  - RUN → DONE after the cycle processing bit WIDTH−1.
  - DONE → IDLE unconditionally after one cycle.
- Arithmetic:
  - carry = carry register after the last bit.
  - overflow = (A[MSB] == B'[MSB]) && (Y[MSB] != A[MSB]), where A and B' are the latched operands.
  - All arithmetic is modulo 2^WIDTH. No saturation.
- Flags carry and overflow update only at the transition into DONE. They hold with Y.
- A start in RUN or DONE is ignored; no queueing. The sequencer must see done before reissuing.
- Operand inputs may change freely after the accepting cycle.
- Reset, asserted at any time including mid-RUN:
  - State goes to IDLE.
  - Y, carry, overflow, busy and done all go to 0.
  - Counter and operand registers clear.
  - The partial result is discarded.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1…WIDTH: RUN, busy = 1.
- Cycle WIDTH+1: DONE, done = 1, busy = 0, Y and flags valid.
- Latency from accepting edge to done is WIDTH+1 cycles, so 9 for the default.
- Throughput: one operation per WIDTH+2 cycles. Back-to-back start is accepted in the cycle after DONE (IDLE).
- done is registered and never asserts in the same cycle as busy.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg holds:
  - the default WIDTH constant
  - the state enum {IDLE, RUN, DONE}
  - the op encoding constants OP_ADD = 0 and OP_SUB = 1.
- Instantiate one full_adder (ports A, B, Cin, Y, Cout) as the only sub-module.
- Counter width is $clog2(WIDTH).

## Test plan
- op = 1, A = 0x05, B = 0x03 → after 9 cycles done = 1, Y = 0x02, carry = 1, overflow = 0.
- op = 1, A = 0x03, B = 0x05 → Y = 0xFE, carry = 0 (borrow), overflow = 0.
- op = 1, A = 0x80, B = 0x01 → Y = 0x7F, overflow = 1, carry = 1. Then op = 0, A = 0x7F, B = 0x01 → Y = 0x80, overflow = 1, carry = 0.
- start pulsed again at cycles 3 and 9 of an operation, with different operands → ignored. The result matches the first operands, and exactly one done pulse occurs.
- rst_n low during cycle 4 of RUN → all outputs read 0 immediately (asynchronous). After release, a new op = 1, A = 0x00, B = 0x01 yields Y = 0xFF, carry = 0.
- Back-to-back: start held high continuously → done pulses every 10 cycles (WIDTH+2) with correct results for the operands present at each accepting IDLE cycle.
